// File: rtl/mem_stage.sv
// Memory stage of the 5-stage RV32I pipeline: EX/MEM register, byte-addressed
// data memory with aligned load/store handling, and the MEM/WB register.
module mem_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_ADDR_BITS = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush_M,
    input  logic [DATA_WIDTH-1:0] ALUout_E,
    input  logic [DATA_WIDTH-1:0] writeData_E,
    input  logic [DATA_WIDTH-1:0] PCPlus4_E,
    input  logic [4:0]            rd_E,
    input  logic                  regWrite_E,
    input  logic                  memWrite_E,
    input  logic [1:0]            resultSrc_E,
    input  logic [2:0]            funct3_E,
    output logic [DATA_WIDTH-1:0] ALUout_M,
    output logic [4:0]            rd_M,
    output logic                  regWrite_M,
    output logic [DATA_WIDTH-1:0] result_W,
    output logic [4:0]            rd_W,
    output logic                  regWrite_W,
    output logic                  misalign_W
);

    localparam logic [MEM_ADDR_BITS-1:0] ADDR_ONE = MEM_ADDR_BITS'(1);

    // Half needs bit 0 clear, word needs bits 1:0 clear; bytes always fit.
    function automatic logic misaligned_f(input logic [2:0] f3, input logic [1:0] lo);
        logic m;
        case (f3[1:0])
            2'b01:   m = lo[0];
            2'b10:   m = (lo != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    logic [DATA_WIDTH-1:0]    alu_m_r, wd_m_r, pc4_m_r;
    logic [4:0]               rd_m_r;
    logic                     regwrite_m_r, memwrite_m_r;
    logic [1:0]               resultsrc_m_r;
    logic [2:0]               funct3_m_r;
    logic [DATA_WIDTH-1:0]    result_w_r;
    logic [4:0]               rd_w_r;
    logic                     regwrite_w_r, misalign_w_r;
    logic [7:0]               mem_r [0:(2**MEM_ADDR_BITS)-1];

    logic [MEM_ADDR_BITS-1:0] addr0_s, addr1_s, addr2_s, addr3_s;
    logic [7:0]               b0_s, b1_s, b2_s, b3_s;
    logic                     misalign_s, store_en_s;
    logic [DATA_WIDTH-1:0]    load_s, result_s;

    // Upper address bits are dropped so neighbouring bytes wrap around memory.
    assign addr0_s    = alu_m_r[MEM_ADDR_BITS-1:0];
    assign addr1_s    = addr0_s + ADDR_ONE;
    assign addr2_s    = addr1_s + ADDR_ONE;
    assign addr3_s    = addr2_s + ADDR_ONE;
    assign b0_s       = mem_r[addr0_s];
    assign b1_s       = mem_r[addr1_s];
    assign b2_s       = mem_r[addr2_s];
    assign b3_s       = mem_r[addr3_s];
    assign misalign_s = (memwrite_m_r || (resultsrc_m_r == 2'b01)) &&
                        misaligned_f(funct3_m_r, alu_m_r[1:0]);
    assign store_en_s = memwrite_m_r && !stall && !misalign_s && !rst;

    // Load extraction and sign/zero extension
    always_comb begin
        load_s = '0;
        case (funct3_m_r)
            3'b000:  load_s = DATA_WIDTH'($signed(b0_s));
            3'b001:  load_s = DATA_WIDTH'($signed({b1_s, b0_s}));
            3'b010:  load_s = DATA_WIDTH'({b3_s, b2_s, b1_s, b0_s});
            3'b100:  load_s = DATA_WIDTH'(b0_s);
            3'b101:  load_s = DATA_WIDTH'({b1_s, b0_s});
            default: load_s = '0;
        endcase
    end

    // Writeback source select; a misaligned access produces zero
    always_comb begin
        result_s = '0;
        if (misalign_s) begin
            result_s = '0;
        end else begin
            case (resultsrc_m_r)
                2'b01:   result_s = load_s;
                2'b10:   result_s = pc4_m_r;
                default: result_s = alu_m_r;
            endcase
        end
    end

    // EX/MEM pipeline register: stall holds and takes priority over flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_m_r       <= '0;
            wd_m_r        <= '0;
            pc4_m_r       <= '0;
            rd_m_r        <= 5'd0;
            regwrite_m_r  <= 1'b0;
            memwrite_m_r  <= 1'b0;
            resultsrc_m_r <= 2'b00;
            funct3_m_r    <= 3'b000;
        end else if (!stall) begin
            if (flush_M) begin
                alu_m_r       <= '0;
                wd_m_r        <= '0;
                pc4_m_r       <= '0;
                rd_m_r        <= 5'd0;
                regwrite_m_r  <= 1'b0;
                memwrite_m_r  <= 1'b0;
                resultsrc_m_r <= 2'b00;
                funct3_m_r    <= 3'b000;
            end else begin
                alu_m_r       <= ALUout_E;
                wd_m_r        <= writeData_E;
                pc4_m_r       <= PCPlus4_E;
                rd_m_r        <= rd_E;
                regwrite_m_r  <= regWrite_E;
                memwrite_m_r  <= memWrite_E;
                resultsrc_m_r <= resultSrc_E;
                funct3_m_r    <= funct3_E;
            end
        end
    end

    // Little-endian byte-lane store; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (store_en_s) begin
            case (funct3_m_r)
                3'b000: mem_r[addr0_s] <= wd_m_r[7:0];
                3'b001: begin
                    mem_r[addr0_s] <= wd_m_r[7:0];
                    mem_r[addr1_s] <= wd_m_r[15:8];
                end
                3'b010: begin
                    mem_r[addr0_s] <= wd_m_r[7:0];
                    mem_r[addr1_s] <= wd_m_r[15:8];
                    mem_r[addr2_s] <= wd_m_r[23:16];
                    mem_r[addr3_s] <= wd_m_r[31:24];
                end
                default: ;
            endcase
        end
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_w_r   <= '0;
            rd_w_r       <= 5'd0;
            regwrite_w_r <= 1'b0;
            misalign_w_r <= 1'b0;
        end else if (!stall) begin
            result_w_r   <= result_s;
            rd_w_r       <= rd_m_r;
            regwrite_w_r <= regwrite_m_r && !misalign_s;
            misalign_w_r <= misalign_s;
        end
    end

    assign ALUout_M   = alu_m_r;
    assign rd_M       = rd_m_r;
    assign regWrite_M = regwrite_m_r && !misalign_s;
    assign result_W   = result_w_r;
    assign rd_W       = rd_w_r;
    assign regWrite_W = regwrite_w_r;
    assign misalign_W = misalign_w_r;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Back-end stage directly downstream of the execute stage in the 5-stage RV32I pipeline.
- Contains the EX/MEM pipeline register, a byte-addressed data memory with load/store alignment and extension, and the MEM/WB pipeline register.
- Consumes the ALU result, store data and control produced in execute.
- Produces M-stage forwarding values and the registered writeback result for the register file.

Parameters:
DATA_WIDTH, 32, datapath width
MEM_ADDR_BITS, 17, data memory size is 2^MEM_ADDR_BITS bytes; the address uses its low MEM_ADDR_BITS bits, upper bits ignored (wrap-around)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
stall  in  1  hold both pipeline registers and suppress memory write
flush_M  in  1  load a bubble into EX/MEM
ALUout_E  in  DATA_WIDTH  ALU result / memory address
writeData_E  in  DATA_WIDTH  store data
PCPlus4_E  in  DATA_WIDTH  link value for jal/jalr
rd_E  in  5  destination register
regWrite_E  in  1  register write enable
memWrite_E  in  1  store enable
resultSrc_E  in  2  00 ALU, 01 memory, 10 PC+4, 11 treated as 00
funct3_E  in  3  access size/sign
ALUout_M  out  DATA_WIDTH  registered ALU result, for forwarding
rd_M  out  5  M-stage destination, for hazard unit
regWrite_M  out  1  M-stage write enable (forced 0 when misaligned)
result_W  out  DATA_WIDTH  writeback value
rd_W  out  5  writeback destination
regWrite_W  out  1  writeback enable
misalign_W  out  1  instruction now in W made a misaligned access

Behaviour:
- Reset (async, active-high): every EX/MEM and MEM/WB field clears to 0, so all outputs are 0 while rst is high and on the first edge after release. Memory contents are not reset. A store in M when rst asserts does not write.
- EX/MEM register, each edge, priority order:
  - rst: clear.
  - stall=1: hold. Stall beats flush.
  - flush_M=1: bubble, i.e. all control (regWrite, memWrite, resultSrc, funct3) = 0 and data = 0.
  - Otherwise: capture the *_E inputs.
- MEM/WB register: holds when stall=1; otherwise captures the M-stage result, rd, gated regWrite and misalign flag.
- Latency: an instruction entering on edge N is in M during cycle N..N+1; its result appears on result_W after edge N+1. Total two edges, with no stall.
- Alignment check in M, using addr = ALUout_M:
  - funct3 x01 (half): misaligned if addr[0]=1.
  - funct3 x10 (word): misaligned if addr[1:0]≠0.
  - Bytes are never misaligned.
  - Only evaluated when memWrite_M=1 or resultSrc_M=01; otherwise misaligned=0.
- Store: on the rising edge when memWrite_M=1, stall=0 and not misaligned. Written once per instruction. Little-endian.
  - funct3 000 (sb): write byte addr ← wd[7:0].
  - funct3 001 (sh): write bytes addr..addr+1 ← wd[15:0].
  - funct3 010 (sw): write addr..addr+3.
  - Other funct3 values: no write.
- Load: combinational read in M from the registered address. Read-during-write to the same address in the same cycle returns the old data.
  - 000 lb: sign-extend byte.
  - 001 lh: sign-extend half.
  - 010 lw: word.
  - 100 lbu: zero-extend byte.
  - 101 lhu: zero-extend half.
  - Others: 0.
- Result mux in M per resultSrc_M; the selected value is registered into result_W.
- Misaligned load: regWrite_M and regWrite_W forced 0, misalign_W=1, result_W = 0.
- Misaligned store: write suppressed, misalign_W=1.
- Byte addresses addr+1..addr+3 wrap modulo 2^MEM_ADDR_BITS.

Test Plan:
- Reset: assert rst mid-cycle with a valid sw in M.
  - All outputs 0 immediately.
  - The target word is unchanged after release.
- Store then load:
  - sw 0xDEADBEEF at 0x100.
  - lb 0x103 → result_W=0xFFFFFFDE, regWrite_W=1.
  - lbu 0x103 → 0x000000DE.
  - lh 0x102 → 0xFFFFDEAD.
  - lhu 0x100 → 0x0000BEEF.
- Partial store: after the above, sb 0x55 at 0x101.
  - lw 0x100 → 0xDEAD55EF.
- Misalignment:
  - lw at 0x102 → misalign_W=1, regWrite_W=0, result_W=0.
  - sh at 0x101 → memory unchanged, misalign_W=1.
- Stall/flush:
  - Stall 3 cycles with sw in M → exactly one write (value visible on the following lw); outputs held constant during the stall.
  - flush_M with a regWrite add in E → next cycle regWrite_M=0 and rd_M=0.
  - stall+flush together → EX/MEM holds.
- Result select:
  - resultSrc=10, PCPlus4_E=0x40 → result_W=0x40 two edges later.
  - resultSrc=00, ALUout_E=0x1234 → ALUout_M=0x1234 after one edge, result_W=0x1234 after two.
